neuron_mac: RTL and testbench

//  Downstream consumer of the per-neuron weight memory: streams one input vector, issues sequential weight reads,

---
 rtl/neuron_mac_pkg.sv | 27 ++
 rtl/fx_saturate.sv | 33 +++
 rtl/neuron_mac.sv | 144 ++++++++++++++
 tb/tb_neuron_mac.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_pkg.sv
// Shared definitions for the neuron datapath stages: FSM state encoding,
// Q-format defaults and a constant-evaluable ceil(log2) helper.
package neuron_mac_pkg;

  localparam int unsigned QDataWidth = 16;
  localparam int unsigned QFracBits  = 12;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StBias,
    StSat
  } state_e;

  // Returns 0 for values of 0 or 1 so a single-weight neuron needs no guard bits.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    longint unsigned span = 1;
    while (span < longint'(value)) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fx_saturate.sv
// Combinational fixed-point narrowing: arithmetic shift right by FRAC_BITS (floor),
// then clamp to the signed OUT_WIDTH range.
module fx_saturate
  import neuron_mac_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 2 * QDataWidth + 10,
  parameter int unsigned OUT_WIDTH = QDataWidth,
  parameter int unsigned FRAC_BITS = QFracBits
) (
  input  logic signed [IN_WIDTH-1:0]  i_acc,
  output logic        [OUT_WIDTH-1:0] o_data
);

  // Rails expressed at input width so the comparison stays fully signed.
  localparam logic signed [IN_WIDTH-1:0] MAX_VAL =
    {{(IN_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_VAL = ~MAX_VAL;

  logic signed [IN_WIDTH-1:0] w_shifted;

  assign w_shifted = i_acc >>> FRAC_BITS;

  always_comb begin
    if (w_shifted > MAX_VAL) begin
      o_data = MAX_VAL[OUT_WIDTH-1:0];
    end else if (w_shifted < MIN_VAL) begin
      o_data = MIN_VAL[OUT_WIDTH-1:0];
    end else begin
      o_data = w_shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate: streams one input vector against sequential weight reads,
// adds the bias and emits one saturated fixed-point pre-activation per vector.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int unsigned NUM_WEIGHT = 784,
  parameter int unsigned DATA_WIDTH = QDataWidth,
  parameter int unsigned FRAC_BITS  = QFracBits,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  w_ren,
  output logic [ADDR_WIDTH-1:0] w_radd,
  input  logic [DATA_WIDTH-1:0] w_dout,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + clog2(NUM_WEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);

  state_e                       r_state;
  logic [ADDR_WIDTH-1:0]        r_idx;
  logic signed [ACC_W-1:0]      r_acc;
  logic [DATA_WIDTH-1:0]        r_out_data;
  logic                         r_out_valid;

  logic signed [DATA_WIDTH-1:0] r_x_d1;
  logic                         r_v1;
  logic signed [PROD_W-1:0]     r_prod;
  logic                         r_v2;

  logic                         w_in_ready;
  logic                         w_accept;
  logic                         w_last;
  logic signed [PROD_W-1:0]     w_x_ext;
  logic signed [PROD_W-1:0]     w_w_ext;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]      w_prod_ext;
  logic signed [ACC_W-1:0]      w_bias_sh;
  logic [DATA_WIDTH-1:0]        w_sat;

  // Gating with rst_n keeps w_ren quiet while reset is asserted.
  assign w_in_ready = rst_n & ((r_state == StIdle) | (r_state == StAccum));
  assign w_accept   = in_valid & w_in_ready;
  assign w_last     = (r_idx == LAST_IDX);

  assign in_ready  = w_in_ready;
  assign w_ren     = w_accept;
  assign w_radd    = r_idx;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != StIdle) | r_v1 | r_v2;

  // Operands widened first so the product is exact at 2*DATA_WIDTH.
  assign w_x_ext    = PROD_W'(r_x_d1);
  assign w_w_ext    = PROD_W'($signed(w_dout));
  assign w_prod     = w_x_ext * w_w_ext;
  assign w_prod_ext = ACC_W'(r_prod);
  assign w_bias_sh  = ACC_W'($signed(bias)) <<< FRAC_BITS;

  fx_saturate #(
    .IN_WIDTH  (ACC_W),
    .OUT_WIDTH (DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat (
    .i_acc  (r_acc),
    .o_data (w_sat)
  );

  // Stage 1 aligns the sample with the registered weight; stage 2 holds the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_d1 <= '0;
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      if (w_accept) begin
        r_x_d1 <= $signed(in_data);
      end
      if (r_v1) begin
        r_prod <= w_prod;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_v2) begin
        r_acc <= r_acc + w_prod_ext;
      end
      unique case (r_state)
        StIdle, StAccum: begin
          if (w_accept) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= StDrain;
            end else begin
              r_idx   <= r_idx + ADDR_WIDTH'(1);
              r_state <= StAccum;
            end
          end
        end
        // Leave once stage 1 is empty; the final product lands in acc on this same edge.
        StDrain: begin
          if (!r_v1) begin
            r_state <= StBias;
          end
        end
        StBias: begin
          r_acc   <= r_acc + w_bias_sh;
          r_state <= StSat;
        end
        StSat: begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_state     <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized scoreboard bench for neuron_mac with a 3-weight vector and a 1-cycle weight memory.
module tb_neuron_mac;

  localparam int unsigned NW = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned FB = 12;
  localparam int unsigned AW = 2;

  typedef logic [DW-1:0] vec_t [NW];
  typedef struct {
    logic [DW-1:0] data;
    int            tl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          w_ren;
  logic [AW-1:0] w_radd;
  logic [DW-1:0] w_dout = '0;
  logic [DW-1:0] bias;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;

  logic [DW-1:0] wmem [4];
  int            cyc = 0;
  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_accepts = 0;
  int            ren_cnt = 0;
  logic [DW-1:0] last_exp = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_ren) w_dout <= wmem[w_radd];
  end

  neuron_mac #(
    .NUM_WEIGHT (NW),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w_ren     (w_ren),
    .w_radd    (w_radd),
    .w_dout    (w_dout),
    .bias      (bias),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Sum of exact products plus scaled bias, floor-divided by 2**FB, clamped to 16-bit signed.
  function automatic logic [DW-1:0] model(input vec_t xs, input vec_t ws, input logic [DW-1:0] b);
    longint s = 0;
    for (int i = 0; i < int'(NW); i++) begin
      s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    end
    s += longint'($signed(b)) * (longint'(1) << FB);
    s = s >>> FB;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[DW-1:0];
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a result.
  initial begin : monitor
    exp_t e;
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (w_ren) ren_cnt++;
      if (out_valid) begin
        check("out_valid_single_cycle", longint'(prev_ov), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", longint'(out_data), longint'(e.data));
          check("result_latency", longint'(cyc - e.tl), 5);
        end
      end
      prev_ov = out_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic send_sample(input logic [DW-1:0] x, input int idx, input bit bubbles,
                             output int t);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    t     = 0;
    if (bubbles) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = x;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        t    = cyc;
        n_accepts++;
        check("w_radd", longint'(w_radd), longint'(idx));
        check("w_ren_on_accept", longint'(w_ren), 1);
      end else begin
        check("w_ren_when_stalled", longint'(w_ren), 0);
        guard++;
        if (guard > 20) begin
          check("accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input vec_t xs, input vec_t ws, input logic [DW-1:0] b,
                            input bit bubbles);
    int   tl;
    exp_t e;
    tl = 0;
    for (int i = 0; i < int'(NW); i++) wmem[i] = ws[i];
    bias = b;
    for (int i = 0; i < int'(NW); i++) send_sample(xs[i], i, bubbles, tl);
    e.data   = model(xs, ws, b);
    e.tl     = tl;
    last_exp = e.data;
    exp_q.push_back(e);
    // Now in cycle tL+1: ready must stay low through tL+4 and return in tL+5.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("in_ready_low_after_last", longint'(in_ready), 0);
      @(posedge clk); #1;
    end
    check("in_ready_back_at_tl5", longint'(in_ready), 1);
  endtask

  function automatic logic [DW-1:0] rand_word(input bit full);
    logic [DW-1:0] v;
    if (full) v = DW'($urandom);
    else v = DW'($urandom_range(0, 16'h3FFF)) - DW'(16'h2000);
    return v;
  endfunction

  initial begin : driver
    vec_t xs;
    vec_t ws;
    int   dummy;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    bias     = '0;
    for (int i = 0; i < 4; i++) wmem[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_w_ren_blocked", longint'(w_ren), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_w_radd", longint'(w_radd), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal vector, contiguous.
    xs = '{16'h0800, 16'h0800, 16'h0800};
    ws = '{16'h1000, 16'h1000, 16'h1000};
    run_vector(xs, ws, 16'h0000, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    // Both saturation rails.
    xs = '{16'h7000, 16'h7000, 16'h7000};
    ws = '{16'h7000, 16'h7000, 16'h7000};
    run_vector(xs, ws, 16'h0000, 1'b0);
    ws = '{16'h8000, 16'h8000, 16'h8000};
    run_vector(xs, ws, 16'h0000, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Bias only, then floor of a tiny negative sum.
    xs = '{16'h0000, 16'h0000, 16'h0000};
    ws = '{16'h1234, 16'h5678, 16'h9ABC};
    run_vector(xs, ws, 16'hF000, 1'b0);
    xs = '{16'h0001, 16'h0000, 16'h0000};
    ws = '{16'hFFFF, 16'h0000, 16'h0000};
    run_vector(xs, ws, 16'h0000, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Nominal vector with input bubbles.
    for (int r = 0; r < 3; r++) begin
      xs = '{16'h0800, 16'h0800, 16'h0800};
      ws = '{16'h1000, 16'h1000, 16'h1000};
      run_vector(xs, ws, 16'h0000, 1'b1);
    end

    // Back-to-back: nominal then floor case, starting in tL+5.
    xs = '{16'h0800, 16'h0800, 16'h0800};
    ws = '{16'h1000, 16'h1000, 16'h1000};
    run_vector(xs, ws, 16'h0000, 1'b0);
    xs = '{16'h0001, 16'h0000, 16'h0000};
    ws = '{16'hFFFF, 16'h0000, 16'h0000};
    run_vector(xs, ws, 16'h0000, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    // Reset after two accepts discards the partial vector.
    ws = '{16'h1000, 16'h1000, 16'h1000};
    for (int i = 0; i < int'(NW); i++) wmem[i] = ws[i];
    bias = '0;
    send_sample(16'h0800, 0, 1'b0, dummy);
    send_sample(16'h0800, 1, 1'b0, dummy);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0800;
    @(negedge clk);
    check("midreset_w_ren_blocked", longint'(w_ren), 0);
    check("midreset_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    check("midreset_idx_cleared", longint'(w_radd), 0);
    check("midreset_busy", longint'(busy), 0);
    repeat (8) begin @(posedge clk); #1; end
    xs = '{16'h0800, 16'h0800, 16'h0800};
    run_vector(xs, ws, 16'h0000, 1'b0);

    // Randomized vectors, mixing full-range and moderate operands.
    for (int n = 0; n < 24; n++) begin
      bit full;
      full = n[0];
      for (int i = 0; i < int'(NW); i++) begin
        xs[i] = rand_word(full);
        ws[i] = rand_word(full);
      end
      run_vector(xs, ws, rand_word(1'b0), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    for (int g = 0; g < 50 && exp_q.size() != 0; g++) @(posedge clk);
    check("scoreboard_drained", longint'(exp_q.size()), 0);
    repeat (5) begin @(posedge clk); #1; end
    check("out_data_holds", longint'(out_data), longint'(last_exp));
    check("busy_idle_at_end", longint'(busy), 0);
    @(negedge clk);
    check("w_ren_total", longint'(ren_cnt), longint'(n_accepts));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
